// File: rtl/multicycle_alu_if.sv
// Handshake and data bundle for multicycle_alu.
//   master : issues requests (start, src1, src2, aluCtrl) and observes results
//   slave  : the ALU itself (busy, done, resultA, resultB, zeroFlag, divByZero)
interface multicycle_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic [2:0]       aluCtrl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] resultA;
  logic [WIDTH-1:0] resultB;
  logic             zeroFlag;
  logic             divByZero;

  modport master (
    output start, src1, src2, aluCtrl,
    input  busy, done, resultA, resultB, zeroFlag, divByZero
  );

  modport slave (
    input  start, src1, src2, aluCtrl,
    output busy, done, resultA, resultB, zeroFlag, divByZero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle ADD/SUB/SHIFT/OR/AND/XOR, iterative unsigned
// shift-add MUL and restoring DIV (one bit per clock, WIDTH iterations).
// Ports:
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset; clears FSM and all outputs
//   bus  : multicycle_alu_if.slave
//          start/src1/src2/aluCtrl in; busy/done/resultA/resultB/
//          zeroFlag/divByZero out. Results change only in the done cycle.
// WIDTH must be a power of two and at least 4.
module multicycle_alu #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rstN,
  multicycle_alu_if.slave    bus
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_MUL   = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_OR    = 3'b101;
  localparam logic [2:0] OP_AND   = 3'b110;
  localparam logic [2:0] OP_XOR   = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic [2:0]       ctrl_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             done_q;
  logic [WIDTH-1:0] res_a_q, res_b_q;
  logic             zero_q, dbz_q;

  logic [WIDTH-1:0] res_a_d, res_b_d;
  logic             dbz_d;
  logic             accept;

  // One shift-add step. {hi,lo} starts as {0, multiplier}; after WIDTH steps
  // it holds the full product. The adder keeps its carry so nothing is lost
  // when the running high half overflows.
  function automatic logic [2*WIDTH-1:0] mul_step(
    input logic [WIDTH-1:0] hi,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] mcand
  );
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    return {sum, lo[WIDTH-1:1]};
  endfunction

  // One restoring-division step. hi is the partial remainder, lo shifts the
  // dividend out of its MSB while quotient bits shift in at the LSB. The
  // shifted remainder needs WIDTH+1 bits; the trial difference's MSB is the
  // borrow that decides whether to restore.
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] rem,
    input logic [WIDTH-1:0] quo,
    input logic [WIDTH-1:0] dvsr
  );
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b1};
    end
    return {shifted[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
  endfunction

  // A request in FINISH is not taken: the FSM returns to IDLE first and the
  // next request is taken in the done cycle.
  assign accept = bus.start && (state_q == IDLE);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if ((bus.aluCtrl == OP_MUL) ||
              ((bus.aluCtrl == OP_DIV) && (bus.src2 != '0))) begin
            state_d = CALC;
          end else begin
            state_d = FINISH;
          end
        end
      end
      CALC: begin
        if (cnt_q == LAST_ITER) begin
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Operand capture and iteration registers; every accept reloads them, so
  // an aborted operation leaves nothing that a later one could observe.
  always_ff @(posedge clk) begin
    if (accept) begin
      op1_q  <= bus.src1;
      op2_q  <= bus.src2;
      ctrl_q <= bus.aluCtrl;
      hi_q   <= '0;
      lo_q   <= (bus.aluCtrl == OP_MUL) ? bus.src2 : bus.src1;
    end else if (state_q == CALC) begin
      if (ctrl_q == OP_MUL) begin
        {hi_q, lo_q} <= mul_step(hi_q, lo_q, op1_q);
      end else begin
        {hi_q, lo_q} <= div_step(hi_q, lo_q, op2_q);
      end
    end
  end

  // Final result selection, consumed only while in FINISH.
  always_comb begin
    res_a_d = '0;
    res_b_d = '0;
    dbz_d   = 1'b0;
    case (ctrl_q)
      OP_ADD: res_a_d = op1_q + op2_q;
      OP_SUB: res_a_d = op1_q - op2_q;
      OP_MUL: begin
        res_a_d = hi_q;
        res_b_d = lo_q;
      end
      OP_DIV: begin
        if (op2_q == '0) begin
          res_a_d = '1;
          res_b_d = op1_q;
          dbz_d   = 1'b1;
        end else begin
          res_a_d = lo_q;
          res_b_d = hi_q;
        end
      end
      OP_SHIFT: begin
        // WIDTH is a power of two, so any set bit above the low SHW bits
        // means the shift amount is at least WIDTH.
        if (|op1_q[WIDTH-1:SHW]) begin
          res_a_d = '0;
        end else begin
          res_a_d = op2_q << op1_q[SHW-1:0];
        end
      end
      OP_OR:  res_a_d = op1_q | op2_q;
      OP_AND: res_a_d = op1_q & op2_q;
      OP_XOR: res_a_d = op1_q ^ op2_q;
      default: res_a_d = '0;
    endcase
  end

  // Output registers: loaded on the edge leaving FINISH, held otherwise.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      done_q  <= 1'b0;
      res_a_q <= '0;
      res_b_q <= '0;
      zero_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= (state_q == FINISH);
      if (state_q == FINISH) begin
        res_a_q <= res_a_d;
        res_b_q <= res_b_d;
        zero_q  <= (res_a_d == '0);
        dbz_q   <= dbz_d;
      end
    end
  end

  assign bus.busy      = (state_q == CALC);
  assign bus.done      = done_q;
  assign bus.resultA   = res_a_q;
  assign bus.resultB   = res_b_q;
  assign bus.zeroFlag  = zero_q;
  assign bus.divByZero = dbz_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32) with a result scoreboard.
module tb_multicycle_alu;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         z;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rstN;
  int   n_checks;
  int   n_err;
  exp_t sb[$];

  multicycle_alu_if #(.WIDTH(W)) bus();

  multicycle_alu #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    e = '0;
    case (op)
      3'd0: e.a = a + b;
      3'd1: e.a = a - b;
      3'd2: begin
        p   = {32'b0, a} * {32'b0, b};
        e.a = p[63:32];
        e.b = p[31:0];
      end
      3'd3: begin
        if (b == 0) begin
          e.a   = '1;
          e.b   = a;
          e.dbz = 1'b1;
        end else begin
          e.a = a / b;
          e.b = a % b;
        end
      end
      3'd4: e.a = (a >= 32) ? '0 : (b << a[4:0]);
      3'd5: e.a = a | b;
      3'd6: e.a = a & b;
      default: e.a = a ^ b;
    endcase
    e.z = (e.a == '0);
    return e;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
    return ((op == 3'd2) || ((op == 3'd3) && (b != 0))) ? 33 : 1;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest request.
  always @(negedge clk) begin
    if (rstN && bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resultA", bus.resultA, e.a);
        chk("resultB", bus.resultB, e.b);
        chk("zeroFlag", bus.zeroFlag, e.z);
        chk("divByZero", bus.divByZero, e.dbz);
        chk("busy_in_done", bus.busy, 0);
      end
    end
  end

  // Called off-edge; returns 1ns after the accepting edge with inputs scrambled.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start   = 1'b1;
    bus.src1    = a;
    bus.src2    = b;
    bus.aluCtrl = op;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.src1    = $urandom;
    bus.src2    = $urandom;
    bus.aluCtrl = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int lat, output int nb);
    nb  = bus.busy ? 1 : 0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk);
      #1;
      lat = k;
      if (bus.done) break;
      if (bus.busy) nb++;
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    int lat, nb, el;
    el = exp_lat(op, b);
    issue(op, a, b);
    wait_done(lat, nb);
    chk("latency", lat, el);
    chk("busy_cycles", nb, (el == 33) ? 32 : 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    int lat, nb;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    n_checks    = 0;
    n_err       = 0;
    rstN        = 1'b0;
    bus.start   = 1'b0;
    bus.src1    = '0;
    bus.src2    = '0;
    bus.aluCtrl = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_resultA", bus.resultA, 0);
    chk("rst_resultB", bus.resultB, 0);
    chk("rst_zero", bus.zeroFlag, 0);
    chk("rst_dbz", bus.divByZero, 0);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    run(3'd0, 32'd7, 32'd2);

    // SUB to zero, then ADD issued in its done cycle
    issue(3'd1, 32'd5, 32'd5);
    wait_done(lat, nb);
    chk("sub_latency", lat, 1);
    issue(3'd0, 32'd1, 32'd1);
    chk("b2b_done_low", bus.done, 0);
    wait_done(lat, nb);
    chk("b2b_latency", lat, 1);
    chk("b2b_resultA", bus.resultA, 2);
    @(posedge clk);
    #1;

    run(3'd2, 32'hFFFF_FFFF, 32'd2);
    run(3'd3, 32'd7, 32'd2);
    run(3'd3, 32'd9, 32'd0);

    // DIV 100/7 with a competing request while busy
    issue(3'd3, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.src1    = 32'd5;
    bus.src2    = 32'd1;
    bus.aluCtrl = 3'd0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(lat, nb);
    chk("div_ignore_latency", 10 + lat, 33);
    @(posedge clk);
    #1;

    run(3'd4, 32'd40, 32'd1);
    run(3'd4, 32'd31, 32'd1);

    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (rop == 3'd4) ra = 32'($urandom_range(0, 40));
      run(rop, ra, rb);
    end

    run(3'd0, 32'd3, 32'd4);

    // Reset asserted mid-MUL
    issue(3'd2, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (14) @(posedge clk);
    #3;
    rstN = 1'b0;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_resultA", bus.resultA, 0);
    chk("midrst_resultB", bus.resultB, 0);
    chk("midrst_zero", bus.zeroFlag, 0);
    chk("midrst_dbz", bus.divByZero, 0);
    sb.delete();
    @(negedge clk);
    rstN = 1'b1;
    run(3'd7, 32'h0000_00F0, 32'h0000_00FF);
    chk("xor_resultA", bus.resultA, 32'h0F);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be >= 4 and a power of two.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port rstN  input  1  reset, asynchronous assert, active-low.
REQ-004 Port start  input  1  request; SHALL be accepted only on a rising edge where busy=0.
REQ-005 Port src1  input  WIDTH  operand 1 (shift amount for SHIFT).
REQ-006 Port src2  input  WIDTH  operand 2.
REQ-007 Port aluCtrl  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 SHIFT, 101 OR, 110 AND, 111 XOR.
REQ-008 Port busy  output  1  multi-cycle operation in progress.
REQ-009 Port done  output  1  one-cycle pulse: results valid.
REQ-010 Port resultA  output  WIDTH  primary result.
REQ-011 Port resultB  output  WIDTH  secondary result (MUL low half, DIV remainder, else 0).
REQ-012 Port zeroFlag  output  1  set when the completed result resultA equals 0.
REQ-013 Port divByZero  output  1  set when the completed operation was DIV with src2=0.

Function
REQ-014 On an accepted start, src1, src2 and aluCtrl SHALL be registered internally; later input changes SHALL NOT affect the operation.
REQ-015 FSM states IDLE, CALC, FINISH; IDLE->FINISH for single-cycle ops and DIV-by-zero, IDLE->CALC for MUL/DIV, CALC->FINISH after WIDTH iterations, FINISH->IDLE unconditionally.
REQ-016 Single-cycle ops (ADD, SUB, SHIFT, OR, AND, XOR): start accepted at edge N -> done=1 during the cycle after edge N+1 (latency 1), busy never asserted.
REQ-017 MUL/DIV: busy=1 from edge N through WIDTH iterations; done=1 for exactly one cycle, WIDTH+1 edges after the accepting edge; busy=0 in the done cycle.
REQ-018 done SHALL be high for one cycle only; a start presented in the done cycle SHALL be accepted (back-to-back issue).
REQ-019 start while busy=1 SHALL be ignored with no effect on state, operands or outputs.
REQ-020 ADD/SUB: resultA = (src1 +/- src2) mod 2^WIDTH; resultB=0.
REQ-021 MUL: unsigned shift-add, one partial product per cycle; {resultA,resultB} = full 2*WIDTH-bit product (resultA high half).
REQ-022 DIV: unsigned restoring, one quotient bit per cycle; resultA=quotient, resultB=remainder.
REQ-023 DIV with src2=0: no iteration; latency 1; resultA=all ones, resultB=src1, divByZero=1.
REQ-024 SHIFT: resultA = src2 logically shifted left by src1; if src1 >= WIDTH, resultA=0; resultB=0.
REQ-025 OR/AND/XOR: bitwise on src1, src2; resultB=0.
REQ-026 resultA, resultB, zeroFlag, divByZero SHALL update only in the done cycle and hold until the next done.
REQ-027 divByZero SHALL be 0 for every completion other than REQ-023.

Reset
REQ-028 rstN=0 SHALL immediately force FSM to IDLE and busy, done, resultA, resultB, zeroFlag, divByZero to 0, including mid-MUL/DIV.
REQ-029 After rstN deasserts, the first rising edge with start=1 SHALL be accepted; no partial state of an aborted operation SHALL persist.

Verification (WIDTH=32)
REQ-030 ADD src1=7, src2=2 -> done next cycle, resultA=9, resultB=0, zeroFlag=0, busy stays 0.
REQ-031 SUB src1=5, src2=5 -> resultA=0, zeroFlag=1; back-to-back ADD 1+1 issued in the done cycle -> resultA=2 one cycle later.
REQ-032 MUL src1=0xFFFFFFFF, src2=2 -> busy 32 cycles, done 33 edges after start, resultA=0x00000001, resultB=0xFFFFFFFE.
REQ-033 DIV 7/2 -> resultA=3, resultB=1, divByZero=0; DIV 9/0 -> done after 1 edge, resultA=0xFFFFFFFF, resultB=9, divByZero=1.
REQ-034 DIV 100/7 with start pulsed again and src1/src2 changed at cycle 10 -> ignored, result 14 remainder 2; SHIFT src1=40, src2=1 -> resultA=0.
REQ-035 Reset asserted at cycle 15 of a MUL -> all outputs 0 immediately; subsequent XOR 0xF0^0xFF -> resultA=0x0F.
